// File: rtl/axi_b_resp_pkg.sv
// Shared constants for the AXI B-response generator: response encodings and
// the FIFO pointer width helper.
package axi_b_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Index bits plus one wrap bit, so full and empty can be told apart
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/b_resp_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; storage is not reset,
// only the pointers are.
module b_resp_fifo
    import axi_b_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full_o    = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) &&
                       (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign empty_o   = (wr_ptr_r == rd_ptr_r);
    // Full refuses a push even when a pop happens in the same cycle
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign data_o    = mem_r[rd_ptr_r[IDX_W-1:0]];

    // Read and write pointer update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage write
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/axi_b_resp_gen.sv
// AXI B-channel response generator: pairs each AW burst with its completed W
// burst in order and emits one B beat carrying the burst's ID/USER and status.
module axi_b_resp_gen
    import axi_b_resp_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int AW_DEPTH   = 4,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  aw_valid_i,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [USER_WIDTH-1:0] aw_user_i,
    output logic                  aw_ready_o,
    input  logic                  w_valid_i,
    input  logic                  w_last_i,
    input  logic                  w_err_i,
    output logic                  w_ready_o,
    output logic                  b_valid_o,
    output logic [1:0]            b_resp_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [USER_WIDTH-1:0] b_user_o,
    input  logic                  b_ready_i
);

    localparam int AWD_W = ID_WIDTH + USER_WIDTH;

    logic             aw_full_s;
    logic             aw_empty_s;
    logic             wb_full_s;
    logic             wb_empty_s;
    logic [AWD_W-1:0] aw_head_s;
    logic [1:0]       wb_head_s;
    logic             aw_hs_s;
    logic             w_hs_s;
    logic             b_hs_s;
    logic             wb_push_s;
    logic [1:0]       wb_resp_s;
    logic             err_acc_r;

    assign aw_ready_o = ~rst_i & ~aw_full_s;
    assign w_ready_o  = ~rst_i & ~wb_full_s;
    assign b_valid_o  = ~rst_i & ~aw_empty_s & ~wb_empty_s;

    assign aw_hs_s   = aw_valid_i & aw_ready_o;
    assign w_hs_s    = w_valid_i & w_ready_o;
    assign b_hs_s    = b_valid_o & b_ready_i;
    assign wb_push_s = w_hs_s & w_last_i;

    // Zero the payload when no response is offered so unwritten storage never leaks out
    assign b_id_o   = b_valid_o ? aw_head_s[AWD_W-1:USER_WIDTH] : '0;
    assign b_user_o = b_valid_o ? aw_head_s[USER_WIDTH-1:0]     : '0;
    assign b_resp_o = b_valid_o ? wb_head_s                     : RESP_OKAY;

    // Burst status: any failed beat, including the last, makes the burst SLVERR
    always_comb begin
        wb_resp_s = RESP_OKAY;
        if (err_acc_r | w_err_i) begin
            wb_resp_s = RESP_SLVERR;
        end else begin
            wb_resp_s = RESP_OKAY;
        end
    end

    // Error accumulation across the beats of the burst in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_acc_r <= 1'b0;
        end else if (w_hs_s) begin
            if (w_last_i) begin
                err_acc_r <= 1'b0;
            end else begin
                err_acc_r <= err_acc_r | w_err_i;
            end
        end else begin
            err_acc_r <= err_acc_r;
        end
    end

    b_resp_fifo #(
        .DATA_WIDTH (AWD_W),
        .DEPTH      (AW_DEPTH)
    ) u_aw_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (aw_hs_s),
        .data_i  ({aw_id_i, aw_user_i}),
        .pop_i   (b_hs_s),
        .data_o  (aw_head_s),
        .full_o  (aw_full_s),
        .empty_o (aw_empty_s)
    );

    b_resp_fifo #(
        .DATA_WIDTH (2),
        .DEPTH      (WB_DEPTH)
    ) u_wb_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wb_push_s),
        .data_i  (wb_resp_s),
        .pop_i   (b_hs_s),
        .data_o  (wb_head_s),
        .full_o  (wb_full_s),
        .empty_o (wb_empty_s)
    );

endmodule

// File: tb/tb_axi_b_resp_gen.sv
// Directed, table-driven bench for axi_b_resp_gen with hand-written sequences
// for backpressure, streaming, reset and simultaneous push/pop.
module tb_axi_b_resp_gen;

    typedef struct {
        logic       rst;
        logic       aw_v;
        logic [3:0] aw_id;
        logic       aw_u;
        logic       w_v;
        logic       w_l;
        logic       w_e;
        logic       b_r;
        logic       e_awr;
        logic       e_wr;
        logic       e_bv;
        logic [1:0] e_resp;
        logic [3:0] e_id;
        logic       e_user;
    } vec_t;

    localparam int NV = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       aw_valid = 1'b0;
    logic [3:0] aw_id = 4'h0;
    logic       aw_user = 1'b0;
    logic       aw_ready;
    logic       w_valid = 1'b0;
    logic       w_last = 1'b0;
    logic       w_err = 1'b0;
    logic       w_ready;
    logic       b_valid;
    logic [1:0] b_resp;
    logic [3:0] b_id;
    logic       b_user;
    logic       b_ready = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    axi_b_resp_gen dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .aw_valid_i (aw_valid),
        .aw_id_i    (aw_id),
        .aw_user_i  (aw_user),
        .aw_ready_o (aw_ready),
        .w_valid_i  (w_valid),
        .w_last_i   (w_last),
        .w_err_i    (w_err),
        .w_ready_o  (w_ready),
        .b_valid_o  (b_valid),
        .b_resp_o   (b_resp),
        .b_id_o     (b_id),
        .b_user_o   (b_user),
        .b_ready_i  (b_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic awv, input logic [3:0] id, input logic u,
                          input logic wv, input logic wl, input logic we, input logic br);
        rst = r; aw_valid = awv; aw_id = id; aw_user = u;
        w_valid = wv; w_last = wl; w_err = we; b_ready = br;
    endtask

    // Payload is compared whenever a response is expected, and during reset (must be 0)
    task automatic exp_out(input string tag, input logic awr, input logic wr, input logic bv,
                           input logic [1:0] resp, input logic [3:0] id, input logic user);
        chk({tag, ".aw_ready"}, aw_ready, awr);
        chk({tag, ".w_ready"}, w_ready, wr);
        chk({tag, ".b_valid"}, b_valid, bv);
        if (bv || rst) begin
            chk({tag, ".b_resp"}, b_resp, resp);
            chk({tag, ".b_id"}, b_id, id);
            chk({tag, ".b_user"}, b_user, user);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb;
        //          rst   awv   id    u     wv    wl    we    br    awr   wr    bv    resp   id    user
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 4'h3, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 4'h7, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 4'h8, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0};

        // Reset, single-beat burst, and a 4-beat burst with a mid-burst error
        for (int i = 0; i < NV; i++) begin
            cyc();
            set_in(vecs[i].rst, vecs[i].aw_v, vecs[i].aw_id, vecs[i].aw_u,
                   vecs[i].w_v, vecs[i].w_l, vecs[i].w_e, vecs[i].b_r);
            #2;
            exp_out($sformatf("vec%0d", i), vecs[i].e_awr, vecs[i].e_wr, vecs[i].e_bv,
                    vecs[i].e_resp, vecs[i].e_id, vecs[i].e_user);
        end

        // Backpressure: fill both FIFOs, stall, then drain in order
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_in(1'b0, 1'b1, 4'(k + 1), 1'b0, 1'b1, 1'b1, (k == 1), 1'b0);
            #2;
            exp_out($sformatf("fill%0d", k), 1'b1, 1'b1, (k > 0), 2'b00, 4'h1, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            set_in(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            #2;
            exp_out($sformatf("stall%0d", k), 1'b0, 1'b0, 1'b1, 2'b00, 4'h1, 1'b0);
        end
        cyc(); set_in(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); #2;
        exp_out("drain0", 1'b0, 1'b0, 1'b1, 2'b00, 4'h1, 1'b0);
        cyc(); #2;
        exp_out("drain1", 1'b1, 1'b1, 1'b1, 2'b10, 4'h2, 1'b0);
        cyc(); set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #2;
        exp_out("drain2", 1'b1, 1'b1, 1'b1, 2'b00, 4'h3, 1'b0);
        cyc(); #2;
        exp_out("drain3", 1'b1, 1'b1, 1'b1, 2'b00, 4'h4, 1'b0);
        cyc(); #2;
        exp_out("drain4", 1'b1, 1'b1, 1'b1, 2'b10, 4'h5, 1'b0);
        cyc(); #2;
        exp_out("drain5", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);

        // Back-to-back stream: one AW and one single-beat W per cycle
        nb = 0;
        for (int i = 0; i <= 20; i++) begin
            cyc();
            if (i < 20) begin
                set_in(1'b0, 1'b1, 4'(i), i[0], 1'b1, 1'b1, (i % 3 == 0), 1'b1);
            end else begin
                set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            #2;
            if (b_valid === 1'b1) nb++;
            if (i > 0) begin
                exp_out($sformatf("stream%0d", i), 1'b1, 1'b1, 1'b1,
                        ((i - 1) % 3 == 0) ? 2'b10 : 2'b00, 4'(i - 1), i[0] ^ 1'b1);
            end else begin
                exp_out("stream0", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
            end
        end
        cyc(); #2;
        exp_out("stream_end", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        chk("stream_count", nb, 20);

        // Reset with pending AWs, an unsent response and a half-finished erroring burst
        cyc(); set_in(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); #2;
        exp_out("rst_pre0", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        cyc(); set_in(1'b0, 1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); #2;
        exp_out("rst_pre1", 1'b1, 1'b1, 1'b1, 2'b00, 4'hA, 1'b0);
        cyc(); set_in(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        exp_out("rst_in", 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0);
        cyc(); set_in(1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); #2;
        exp_out("rst_post0", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        cyc(); set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #2;
        exp_out("rst_post1", 1'b1, 1'b1, 1'b1, 2'b00, 4'h9, 1'b0);
        cyc(); #2;
        exp_out("rst_post2", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);

        // AW push, WLAST push and B pop in one cycle with one entry per FIFO
        cyc(); set_in(1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); #2;
        exp_out("simul0", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        cyc(); set_in(1'b0, 1'b1, 4'hD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); #2;
        exp_out("simul1", 1'b1, 1'b1, 1'b1, 2'b10, 4'hC, 1'b1);
        cyc(); set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
        exp_out("simul2", 1'b1, 1'b1, 1'b1, 2'b00, 4'hD, 1'b0);
        cyc(); set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #2;
        exp_out("simul3", 1'b1, 1'b1, 1'b1, 2'b00, 4'hD, 1'b0);
        cyc(); #2;
        exp_out("simul4", 1'b1, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_b_resp_gen.md
Name: axi_b_resp_gen

Overview:
- Generates AXI write responses (B channel) for a memory-side write slave.
- Pairs each accepted AW burst with the completion of its W burst, the W beat carrying WLAST.
- Emits one B beat per burst, with the burst's ID/USER and an OKAY or SLVERR response.
- Sits directly upstream of the B-channel buffer slice; its B outputs connect to that slice's slave-side B inputs.

Parameters:
- ID_WIDTH, 4, width of AXI ID field
- USER_WIDTH, 1, width of AXI USER field
- AW_DEPTH, 4, entries in AW ID/USER FIFO; power of two, >=2
- WB_DEPTH, 4, entries in completed-W-burst response FIFO; power of two, >=2

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- aw_valid_i  in  1  AW request valid
- aw_id_i  in  ID_WIDTH  AW ID
- aw_user_i  in  USER_WIDTH  AW USER
- aw_ready_o  out  1  AW accepted when valid&ready
- w_valid_i  in  1  W beat valid
- w_last_i  in  1  last beat of burst
- w_err_i  in  1  beat write failed at memory side
- w_ready_o  out  1  W beat accepted when valid&ready
- b_valid_o  out  1  B response valid
- b_resp_o  out  2  B response: 2'b00 OKAY, 2'b10 SLVERR
- b_id_o  out  ID_WIDTH  B ID
- b_user_o  out  USER_WIDTH  B USER
- b_ready_i  in  1  downstream accepts B

Behaviour:
- Reset (rst_i high at clock edge): both FIFOs empty, error accumulator 0.
  - While rst_i is high: aw_ready_o=0, w_ready_o=0, b_valid_o=0; b_resp_o/b_id_o/b_user_o=0.
  - Reset mid-burst discards all pending AW entries, partial W error state and unsent responses; no B is produced for them.
- AW path:
  - aw_ready_o = !rst_i & !aw_fifo_full.
  - On handshake, push {id,user}.
  - No bypass: a full FIFO refuses push even if popped the same cycle.
- W path:
  - w_ready_o = !rst_i & !wb_fifo_full, applied to every beat, not only the last.
  - Error accumulator err_acc: on an accepted beat with w_last_i=0, err_acc <= err_acc | w_err_i.
  - On an accepted beat with w_last_i=1, push resp = (err_acc|w_err_i) ? 2'b10 : 2'b00, and clear err_acc.
  - Single-beat bursts (w_last_i on the first beat) are legal.
- Ordering: W bursts may complete before their AW arrives; the pairing is strictly in order (nth AW with nth WLAST).
- B path:
  - b_valid_o = !aw_fifo_empty & !wb_fifo_empty.
  - b_id_o/b_user_o come from the AW FIFO head; b_resp_o comes from the WB FIFO head.
  - Pop both FIFOs on b_valid_o & b_ready_i.
  - While b_valid_o=1 and b_ready_i=0, all B outputs stay stable (AXI rule).
- Latency: when the later of the AW handshake and the WLAST handshake occurs at edge N (FIFOs previously empty), b_valid_o rises in the cycle following edge N (one-cycle latency). With b_ready_i held high, throughput is one B per cycle.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle leaves the count unchanged.
  - An AW push, a WLAST push and a B pop in the same cycle are all honoured.
- Wrap-around: FIFO pointers are log2(DEPTH) bits wide plus one wrap bit; full = pointers equal except the wrap bit; empty = all bits equal.
- Outputs are never X after reset; FIFO storage itself is not reset.

Decomposition:
- Package axi_b_resp_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 (RESP_EXOKAY/DECERR reserved, not generated)
  - localparam function for the pointer width.
- One sub-module: b_resp_fifo
  - Parameterised DATA_WIDTH, DEPTH; synchronous active-high reset.
  - Ports push/pop/full/empty/data_o; first-word-fall-through head.
  - Instantiated twice: AW data {id,user} and WB resp.

Test Plan:
- AW id=4'h3 user=1 then one-beat W (last=1, err=0), b_ready_i=1 -> b_valid_o one cycle after the W handshake, b_id_o=3, b_user_o=1, b_resp_o=00, then b_valid_o=0.
- W burst of 4 beats with w_err_i=1 on beat 2 only, AW id=4'h7 issued 3 cycles after WLAST -> b_resp_o=2'b10, b_id_o=7, b_valid_o one cycle after the AW handshake; a following clean burst returns 2'b00, confirming the error clear.
- b_ready_i=0, issue 4 AW (ids 1..4) plus a 5th and 4 bursts -> aw_ready_o=0 with the 5th AW pending, w_ready_o=0 on beats after the 4th WLAST; raise b_ready_i -> B ids 1,2,3,4 in order, 5th AW accepted on the first pop cycle +1, b_* stable while stalled.
- Continuous back-to-back: AW and single-beat W every cycle for 20 cycles, b_ready_i=1 -> 20 B beats, one per cycle, ids in order, both FIFO pointers wrap ≥4 times, no drops.
- rst_i asserted for 1 cycle with 2 AW pending and a half-finished W burst containing err=1 -> b_valid_o=0 and ready outputs 0 during reset; afterwards a new AW id=9 plus a clean one-beat W yields exactly one B: id=9, resp=00.
- Same-cycle AW push, WLAST push and B pop with each FIFO holding 1 entry -> occupancy stays 1 per FIFO, next B has the correct next id/resp pair.
